small_calc_arbiter: RTL and testbench

//  Shares one small_calc instance (go/done handshake, 4-bit operands, 2-bit op) between N_REQ requesters.

---
 rtl/small_calc_arbiter_pkg.sv | 25 ++
 rtl/small_calc_arbiter_rr_arbiter.sv | 34 +++
 rtl/small_calc_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_small_calc_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/small_calc_arbiter_pkg.sv
// Shared types and constants for the small_calc arbiter and its requesters.
package small_calc_arbiter_pkg;

  // Operand/result width of the shared small_calc datapath.
  localparam int CALC_DW = 4;

  // Op-code field width; op codes are passed through to small_calc untouched.
  localparam int OP_W = 2;

  // Op code 0 is addition in small_calc; the arbiter never interprets op codes.
  localparam logic [OP_W-1:0] OP_ADD = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Next round-robin start position after serving requester idx out of n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/small_calc_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  int   cand;
  logic found;

  // Scan from ptr upward (modulo N_REQ) and keep the first requester seen.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/small_calc_arbiter.sv
// Shares one small_calc between N_REQ requesters with round-robin grant,
// operand latching, go/done handshake and a watchdog abort.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for any req; picks winner, latches its operands
// ST_ISSUE | calc_go pulse for one cycle, watchdog cleared
// ST_WAIT  | waiting for calc_done; watchdog counts, aborts at TIMEOUT-1
// ST_RESP  | rsp_valid pulse to winner, rr pointer advances past winner
module small_calc_arbiter
  import small_calc_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = CALC_DW,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ*DW-1:0]   req_in1_i,
  input  logic [N_REQ*DW-1:0]   req_in2_i,
  input  logic [N_REQ*OP_W-1:0] req_op_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [N_REQ-1:0]      rsp_valid_o,
  output logic [DW-1:0]         rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  calc_go_o,
  output logic [DW-1:0]         calc_in1_o,
  output logic [DW-1:0]         calc_in2_o,
  output logic [OP_W-1:0]       calc_op_o,
  input  logic                  calc_done_i,
  input  logic [DW-1:0]         calc_out_i
);

  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT);

  arb_state_e state_q, state_d;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_REQ-1:0] sel_q, sel_d;
  logic [DW-1:0]    in1_q, in1_d;
  logic [DW-1:0]    in2_q, in2_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [DW-1:0]    res_q, res_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;
  logic [DW-1:0]    win_in1;
  logic [DW-1:0]    win_in2;
  logic [OP_W-1:0]  win_op;
  logic             wd_hit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign win_in1 = req_in1_i[arb_idx*DW +: DW];
  assign win_in2 = req_in2_i[arb_idx*DW +: DW];
  assign win_op  = req_op_i[arb_idx*OP_W +: OP_W];

  // Watchdog expires on the last permitted WAIT cycle; a done in that same cycle still wins.
  assign wd_hit = (wd_q == WDW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the sequence is fixed, only IDLE and WAIT have exits that depend on inputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arb_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (calc_done_i || wd_hit) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: grant latch in IDLE, watchdog and result capture in ISSUE/WAIT, pointer in RESP.
  always_comb begin
    ptr_d = ptr_q;
    idx_d = idx_q;
    sel_d = sel_q;
    in1_d = in1_q;
    in2_d = in2_q;
    op_d  = op_q;
    wd_d  = wd_q;
    res_d = res_q;
    err_d = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          idx_d = arb_idx;
          sel_d = arb_gnt;
          in1_d = win_in1;
          in2_d = win_in2;
          op_d  = win_op;
        end
      end
      ST_ISSUE: begin
        wd_d = '0;
      end
      ST_WAIT: begin
        if (calc_done_i) begin
          res_d = calc_out_i;
          err_d = 1'b0;
        end else if (wd_hit) begin
          res_d = '0;
          err_d = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_RESP: begin
        ptr_d = IW'(rr_next(int'(idx_q), N_REQ));
      end
      default: begin
        ptr_d = ptr_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      idx_q <= '0;
      sel_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      op_q  <= '0;
      wd_q  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      op_q  <= op_d;
      wd_q  <= wd_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  // Outputs decoded from registered state only, so every one drops to 0 with the async reset.
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    gnt_o       = (state_q != ST_IDLE) ? sel_q : '0;
    calc_go_o   = (state_q == ST_ISSUE);
    rsp_valid_o = (state_q == ST_RESP) ? sel_q : '0;
    rsp_data_o  = (state_q == ST_RESP) ? res_q : '0;
    rsp_err_o   = (state_q == ST_RESP) && err_q;
    calc_in1_o  = in1_q;
    calc_in2_o  = in2_q;
    calc_op_o   = op_q;
  end

endmodule

// File: tb/tb_small_calc_arbiter.sv
// Bench for small_calc_arbiter: vector table, hand sequences and random traffic vs a reference model.
module tb_small_calc_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [15:0]  req_in1;
  logic [15:0]  req_in2;
  logic [7:0]   req_op;
  logic [3:0]   gnt;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         calc_go;
  logic [3:0]   calc_in1;
  logic [3:0]   calc_in2;
  logic [1:0]   calc_op;
  logic         calc_done;
  logic [3:0]   calc_out;

  int n_pass;
  int n_total;
  int ptr_m;

  small_calc_arbiter #(
    .N_REQ   (N),
    .DW      (4),
    .TIMEOUT (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .req_in1_i   (req_in1),
    .req_in2_i   (req_in2),
    .req_op_i    (req_op),
    .gnt_o       (gnt),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .calc_go_o   (calc_go),
    .calc_in1_o  (calc_in1),
    .calc_in2_o  (calc_in2),
    .calc_op_o   (calc_op),
    .calc_done_i (calc_done),
    .calc_out_i  (calc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] mask;
    int         k;
    logic [3:0] cout;
    int         exp_idx;
    logic [3:0] exp_data;
    logic       exp_err;
    bit         drop;
    bit         stray;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int o = 0; o < N; o++) begin
      if (m[(p + o) % N]) return (p + o) % N;
    end
    return 0;
  endfunction

  // One full transaction from an IDLE cycle: k in 1..TO gives done k cycles after calc_go,
  // anything else means small_calc never answers.
  task automatic run_txn(input logic [3:0] mask, input int k, input logic [3:0] cout,
                         input int exp_idx, input logic [3:0] exp_data, input logic exp_err,
                         input bit drop);
    logic [9:0] ops;
    logic [3:0] oh;
    int         nwait;
    oh    = 4'b0001 << exp_idx;
    ops   = {req_in1[exp_idx*4 +: 4], req_in2[exp_idx*4 +: 4], req_op[exp_idx*2 +: 2]};
    nwait = (k >= 1 && k <= TO) ? k : TO;
    req   = mask;
    cyc();
    chk("issue", 32'({calc_go, busy, rsp_valid, gnt, calc_in1, calc_in2, calc_op}),
        32'({1'b1, 1'b1, 4'b0000, oh, ops}));
    if (drop) begin
      req = 4'b0000;
      req_in1[exp_idx*4 +: 4] = ~req_in1[exp_idx*4 +: 4];
    end
    cyc();
    for (int j = 1; j <= nwait; j++) begin
      chk("wait", 32'({calc_go, busy, rsp_valid, gnt, calc_in1, calc_in2, calc_op}),
          32'({1'b0, 1'b1, 4'b0000, oh, ops}));
      if (j == k) begin
        calc_done = 1'b1;
        calc_out  = cout;
      end
      cyc();
      calc_done = 1'b0;
      calc_out  = 4'h0;
    end
    chk("resp", 32'({rsp_valid, rsp_data, rsp_err, gnt, calc_go, busy}),
        32'({oh, exp_data, exp_err, oh, 1'b0, 1'b1}));
    req = 4'b0000;
    cyc();
    chk("idle", 32'({busy, gnt, rsp_valid, rsp_data, rsp_err, calc_go}), 32'(0));
  endtask

  initial begin
    logic [3:0] m;
    logic [3:0] co;
    int         k;
    int         w;

    n_pass    = 0;
    n_total   = 0;
    ptr_m     = 0;
    rst_n     = 1'b0;
    req       = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_op    = '0;
    calc_done = 1'b0;
    calc_out  = '0;

    //            mask     k  cout  idx data  err  drop stray
    tbl[0]  = '{4'b1111, 1, 4'd1,  0, 4'd1,  1'b0, 0, 0};
    tbl[1]  = '{4'b1111, 1, 4'd2,  1, 4'd2,  1'b0, 0, 0};
    tbl[2]  = '{4'b1111, 2, 4'd3,  2, 4'd3,  1'b0, 0, 0};
    tbl[3]  = '{4'b1111, 1, 4'd4,  3, 4'd4,  1'b0, 0, 0};
    tbl[4]  = '{4'b1111, 1, 4'd5,  0, 4'd5,  1'b0, 0, 0};
    tbl[5]  = '{4'b0010, 3, 4'd8,  1, 4'd8,  1'b0, 0, 0};
    tbl[6]  = '{4'b0001, 0, 4'd9,  0, 4'd0,  1'b1, 0, 1};
    tbl[7]  = '{4'b1001, 8, 4'd9,  3, 4'd9,  1'b0, 0, 0};
    tbl[8]  = '{4'b0110, 2, 4'd15, 1, 4'd15, 1'b0, 0, 0};
    tbl[9]  = '{4'b0100, 4, 4'd6,  2, 4'd6,  1'b0, 1, 0};
    tbl[10] = '{4'b0101, 5, 4'd7,  0, 4'd7,  1'b0, 0, 0};
    tbl[11] = '{4'b1010, 1, 4'd0,  1, 4'd0,  1'b0, 0, 0};

    for (int i = 0; i < N; i++) begin
      req_in1[i*4 +: 4] = 4'(4 + i);
      req_in2[i*4 +: 4] = 4'(2 + i);
      req_op[i*2 +: 2]  = 2'((i + 3) % 4);
    end

    #12;
    chk("reset_state", 32'({gnt, rsp_valid, rsp_data, rsp_err, busy, calc_go, calc_in1, calc_in2, calc_op}), 32'(0));
    rst_n = 1'b1;
    cyc();
    chk("reset_idle", 32'({busy, gnt, calc_go}), 32'(0));

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].mask, tbl[i].k, tbl[i].cout, tbl[i].exp_idx, tbl[i].exp_data,
              tbl[i].exp_err, tbl[i].drop);
      ptr_m = (tbl[i].exp_idx + 1) % N;
      if (tbl[i].stray) begin
        calc_done = 1'b1;
        calc_out  = 4'hA;
        cyc();
        chk("stray_done", 32'({busy, gnt, rsp_valid, calc_go}), 32'(0));
        cyc();
        chk("stray_done2", 32'({busy, gnt, rsp_valid, calc_go}), 32'(0));
        calc_done = 1'b0;
        calc_out  = 4'h0;
      end
    end

    for (int r = 0; r < 40; r++) begin
      m  = 4'($urandom_range(1, 15));
      k  = int'($urandom_range(1, TO + 2));
      co = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_in1[i*4 +: 4] = 4'($urandom_range(0, 15));
        req_in2[i*4 +: 4] = 4'($urandom_range(0, 15));
        req_op[i*2 +: 2]  = 2'($urandom_range(0, 3));
      end
      w = rr_pick(m, ptr_m);
      run_txn(m, k, co, w, (k <= TO) ? co : 4'd0, (k > TO), r[2] & r[0]);
      ptr_m = (w + 1) % N;
    end

    req = 4'b0100;
    cyc();
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({gnt, rsp_valid, rsp_data, rsp_err, busy, calc_go, calc_in1, calc_in2, calc_op}), 32'(0));
    req = 4'b0000;
    cyc();
    rst_n = 1'b1;
    ptr_m = 0;
    run_txn(4'b1111, 2, 4'd3, 0, 4'd3, 1'b0, 0);
    run_txn(4'b1111, 1, 4'd12, 1, 4'd12, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
